// File: rtl/sub_serial_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial_gen_if
// Description : Handshake and operand/result bundle for sub_serial_gen.
//               The ovf member exists only when SUB_SERIAL_OVF_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface sub_serial_gen_if #(
    parameter int N = 16
);
    logic         start;
    logic         bin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
`ifdef SUB_SERIAL_OVF_EN
    logic         ovf;

    modport master (
        output start, bin, a, b,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, bin, a, b,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, bin, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, bin, a, b,
        output busy, done, diff, bout
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sub_serial_gen.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial_gen
// Description : Digit-serial subtractor, diff = a - b - bin over N/K cycles
//               using a K-cell full-subtractor chain per cycle.
//               Optional macro SUB_SERIAL_OVF_EN adds a signed-overflow flag.
// Revision    : 1.0  initial release
// ============================================================================
module sub_serial_gen #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sub_serial_gen_if.slave  bus
);

    localparam int            DIGITS = N / K;
    localparam int            CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST   = CW'(DIGITS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_load;
    logic          w_step;
    logic          w_last;

    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_res;
    logic          r_br;
    logic [CW-1:0] r_cnt;

    logic          r_done;
    logic [N-1:0]  r_diff;
    logic          r_bout;

    logic [K:0]    w_br;
    logic [K-1:0]  w_d;
    logic [N-1:0]  w_res_next;

    // One digit of ripple borrow: cell i consumes bit i of the shifted operands.
    assign w_br[0] = r_br;

    for (genvar i = 0; i < K; i++) begin : g_cell
        logic w_x;
        logic w_y;
        assign w_x       = r_a[i];
        assign w_y       = r_b[i];
        assign w_d[i]    = w_x ^ w_y ^ w_br[i];
        assign w_br[i+1] = (~w_x & w_y) | (~(w_x ^ w_y) & w_br[i]);
    end

    // New digit enters at the top so the LSB digit ends up at the bottom.
    assign w_res_next = (r_res >> K) | (N'(w_d) << (N - K));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_br  <= bus.bin;
                r_cnt <= '0;
                r_res <= '0;
            end else if (w_step) begin
                r_a   <= r_a >> K;
                r_b   <= r_b >> K;
                r_br  <= w_br[K];
                r_cnt <= r_cnt + 1'b1;
                r_res <= w_res_next;
            end
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= w_br[K];
            end
        end
    end

`ifdef SUB_SERIAL_OVF_EN
    logic r_sa;
    logic r_sb;
    logic r_ovf;

    // Sign bits are kept separately because the operand registers shift away.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_load) begin
                r_sa <= bus.a[N-1];
                r_sb <= bus.b[N-1];
            end
            if (w_last) begin
                r_ovf <= (r_sa ^ r_sb) & (r_sa ^ w_res_next[N-1]);
            end
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;

endmodule
`default_nettype wire
